// File: rtl/llc_fifo_proc_update_if.sv
// Handshake bundle between the LLC process stage, the process-to-update FIFO,
// and the update stage.
interface llc_fifo_proc_update_if #(
  parameter int PKT_W = 9,
  parameter int CNT_W = 3
);
  logic             fifo_push;
  logic [PKT_W-1:0] fifo_in;
  logic             fifo_pop;
  logic [PKT_W-1:0] fifo_out;
  logic             fifo_empty;
  logic             fifo_full;
  logic [CNT_W-1:0] fifo_count;
  logic             patch_en;
  logic [PKT_W-1:0] patch_mask;
  logic [PKT_W-1:0] patch_data;
  logic             err_overflow;
  logic             err_underflow;

  modport master (
    output fifo_push, fifo_in, fifo_pop, patch_en, patch_mask, patch_data,
    input  fifo_out, fifo_empty, fifo_full, fifo_count, err_overflow, err_underflow
  );

  modport slave (
    input  fifo_push, fifo_in, fifo_pop, patch_en, patch_mask, patch_data,
    output fifo_out, fifo_empty, fifo_full, fifo_count, err_overflow, err_underflow
  );
endinterface

// File: rtl/llc_fifo_proc_update.sv
// Process-to-update packet FIFO with an in-place head patch so the process
// stage can amend DMA resume flags of a packet that is already queued.
module llc_fifo_proc_update #(
  parameter int DEPTH = 4,
  parameter int PKT_W = 9,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  llc_fifo_proc_update_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             err_overflow;
  logic             err_underflow;

  logic             empty;
  logic             full;
  logic             push_acc;
  logic             pop_acc;
  logic             patch_wr;
  logic [PKT_W-1:0] head;
  logic [PKT_W-1:0] merged;

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(DEPTH));
  assign pop_acc  = bus.fifo_pop && !empty;
  // A full FIFO is never empty, so a pop alongside a push always frees a slot.
  assign push_acc = bus.fifo_push && (!full || bus.fifo_pop);
  assign head     = mem[rd_ptr];
  assign merged   = (head & ~bus.patch_mask) | (bus.patch_data & bus.patch_mask);
  // When the head is consumed this cycle the merge is only what the update
  // stage sees; storing it would be pointless and could collide with a push.
  assign patch_wr = bus.patch_en && !empty && !pop_acc;

  assign bus.fifo_out      = empty ? '0 : (bus.patch_en ? merged : head);
  assign bus.fifo_empty    = empty;
  assign bus.fifo_full     = full;
  assign bus.fifo_count    = count;
  assign bus.err_overflow  = err_overflow;
  assign bus.err_underflow = err_underflow;

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push_acc) mem[wr_ptr] <= bus.fifo_in;
      if (patch_wr) mem[rd_ptr] <= merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
      count         <= count + CNT_W'(push_acc) - CNT_W'(pop_acc);
      err_overflow  <= err_overflow  | (bus.fifo_push && !push_acc);
      err_underflow <= err_underflow | (bus.fifo_pop && empty);
    end
  end
endmodule
